// File: rtl/marco_polo_responder.sv
// Answers each MARCO match with "POLO" (plus optional CR LF), one byte per uart_tx handshake.
// Holds one queued request, times out missing acknowledges and counts completed replies.
module marco_polo_responder #(
  parameter int APPEND_CRLF = 1,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       match,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       reply_busy,
  output logic       reply_done,
  output logic       dropped,
  output logic       ack_error,
  output logic [7:0] reply_count
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, GAP} state_t;

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [2:0]    LAST_IDX = (APPEND_CRLF != 0) ? 3'd5 : 3'd3;
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

  function automatic logic [7:0] reply_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    reply_byte = 8'h50;
      3'd1:    reply_byte = 8'h4F;
      3'd2:    reply_byte = 8'h4C;
      3'd3:    reply_byte = 8'h4F;
      3'd4:    reply_byte = 8'h0D;
      3'd5:    reply_byte = 8'h0A;
      default: reply_byte = 8'h00;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [TW-1:0] ack_q, ack_d;
  logic [7:0]    gap_q, gap_d;
  logic          tx_start_d, reply_busy_d, reply_done_d, dropped_d, ack_error_d;
  logic [7:0]    tx_data_d, count_d;
  logic          accept, trigger, issue;
  logic [2:0]    issue_idx;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    ack_d        = ack_q;
    gap_d        = gap_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data;
    reply_done_d = 1'b0;
    dropped_d    = 1'b0;
    ack_error_d  = 1'b0;
    count_d      = reply_count;
    issue        = 1'b0;
    issue_idx    = idx_q;

    accept  = match & enable;
    trigger = accept | (pending_q & enable);

    if (accept) begin
      if (pending_q) dropped_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger && !tx_busy) begin
          // A queued request is consumed here; a fresh match in the same cycle takes its place
          dropped_d = 1'b0;
          pending_d = pending_q & accept;
          idx_d     = 3'd0;
          issue     = 1'b1;
          issue_idx = 3'd0;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          ack_d   = '0;
        end else if (ack_q == ACK_LAST) begin
          ack_error_d = 1'b1;
          state_d     = IDLE;
          idx_d       = 3'd0;
          ack_d       = '0;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            reply_done_d = 1'b1;
            count_d      = reply_count + 8'd1;
            state_d      = IDLE;
            idx_d        = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
            if (GAP_CYCLES == 0) begin
              issue     = 1'b1;
              issue_idx = idx_q + 3'd1;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          issue = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      tx_start_d = 1'b1;
      tx_data_d  = reply_byte(issue_idx);
      state_d    = WAIT_ACK;
      ack_d      = '0;
    end

    if (!enable) pending_d = 1'b0;

    reply_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      ack_q       <= '0;
      gap_q       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      reply_busy  <= 1'b0;
      reply_done  <= 1'b0;
      dropped     <= 1'b0;
      ack_error   <= 1'b0;
      reply_count <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      gap_q       <= gap_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      reply_busy  <= reply_busy_d;
      reply_done  <= reply_done_d;
      dropped     <= dropped_d;
      ack_error   <= ack_error_d;
      reply_count <= count_d;
    end
  end

endmodule

// File: tb/tb_marco_polo_responder.sv
// Directed bench for marco_polo_responder: a CRLF/no-gap instance and a no-CRLF/gap-3 instance,
// each driven by a simple uart_tx busy model or by hand.
module tb_marco_polo_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, match0, match1, tx_busy0, tx_busy1;
  logic       tx_start0, reply_busy0, reply_done0, dropped0, ack_error0;
  logic       tx_start1, reply_busy1, reply_done1, dropped1, ack_error1;
  logic [7:0] tx_data0, reply_count0, tx_data1, reply_count1;

  marco_polo_responder #(.APPEND_CRLF(1), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .match(match0), .tx_busy(tx_busy0),
    .tx_start(tx_start0), .tx_data(tx_data0), .reply_busy(reply_busy0),
    .reply_done(reply_done0), .dropped(dropped0), .ack_error(ack_error0),
    .reply_count(reply_count0));

  marco_polo_responder #(.APPEND_CRLF(0), .GAP_CYCLES(3), .ACK_TIMEOUT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .match(match1), .tx_busy(tx_busy1),
    .tx_start(tx_start1), .tx_data(tx_data1), .reply_busy(reply_busy1),
    .reply_done(reply_done1), .dropped(dropped1), .ack_error(ack_error1),
    .reply_count(reply_count1));

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // busy model state per instance
  bit model_on0, model_on1;
  int rise0, hold0, delay_left0, busy_left0;
  int rise1, hold1, delay_left1, busy_left1;
  bit prev_busy1;

  int         start_cyc0[$], done_cyc0[$], drop_cyc0[$], err_cyc0[$];
  logic [7:0] start_dat0[$];
  int         start_cyc1[$], done_cyc1[$], err_cyc1[$], fall_cyc1[$];
  logic [7:0] start_dat1[$];

  typedef struct {
    logic       en;
    logic       m;
    logic       busy;
    logic       exp_start;
    logic       exp_rbusy;
    logic       exp_drop;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         offset;
  } byte_exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start0 === 1'b1) begin start_cyc0.push_back(cyc); start_dat0.push_back(tx_data0); end
    if (reply_done0 === 1'b1) done_cyc0.push_back(cyc);
    if (dropped0 === 1'b1) drop_cyc0.push_back(cyc);
    if (ack_error0 === 1'b1) err_cyc0.push_back(cyc);
    if (tx_start1 === 1'b1) begin start_cyc1.push_back(cyc); start_dat1.push_back(tx_data1); end
    if (reply_done1 === 1'b1) done_cyc1.push_back(cyc);
    if (ack_error1 === 1'b1) err_cyc1.push_back(cyc);

    if (delay_left0 > 0) begin delay_left0--; if (delay_left0 == 0) busy_left0 = hold0; end
    if (model_on0) tx_busy0 = (busy_left0 > 0);
    if (busy_left0 > 0) busy_left0--;
    if (model_on0 && tx_start0 === 1'b1) delay_left0 = rise0;

    if (delay_left1 > 0) begin delay_left1--; if (delay_left1 == 0) busy_left1 = hold1; end
    if (model_on1) tx_busy1 = (busy_left1 > 0);
    if (busy_left1 > 0) busy_left1--;
    if (model_on1 && tx_start1 === 1'b1) delay_left1 = rise1;
    if (prev_busy1 && !tx_busy1) fall_cyc1.push_back(cyc);
    prev_busy1 = tx_busy1;
  endtask

  task automatic clear_logs();
    start_cyc0.delete(); start_dat0.delete(); done_cyc0.delete(); drop_cyc0.delete();
    err_cyc0.delete(); start_cyc1.delete(); start_dat1.delete(); done_cyc1.delete();
    err_cyc1.delete(); fall_cyc1.delete();
  endtask

  task automatic model0(input bit on, input int rise, input int hold);
    model_on0 = on; rise0 = rise; hold0 = hold;
    delay_left0 = 0; busy_left0 = 0; tx_busy0 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; match0 = 1'b0; match1 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse0();
    match0 = 1'b1; tick(); match0 = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_tx_start"}, tx_start0, 0);
    check({tag, "_tx_data"}, tx_data0, 0);
    check({tag, "_reply_busy"}, reply_busy0, 0);
    check({tag, "_reply_done"}, reply_done0, 0);
    check({tag, "_dropped"}, dropped0, 0);
    check({tag, "_ack_error"}, ack_error0, 0);
    check({tag, "_reply_count"}, reply_count0, 0);
  endtask

  vec_t      vecs[12];
  byte_exp_t crlf_bytes[6];
  byte_exp_t gap_bytes[4];
  int        m;

  initial begin
    //           en    m     busy  start rbusy drop  data
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h50};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h50};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h50};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4F};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4F};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4F};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4C};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4C};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4C};
    crlf_bytes = '{'{8'h50, 0}, '{8'h4F, 12}, '{8'h4C, 24}, '{8'h4F, 36}, '{8'h0D, 48}, '{8'h0A, 60}};
    gap_bytes  = '{'{8'h50, 0}, '{8'h4F, 15}, '{8'h4C, 30}, '{8'h4F, 45}};

    enable = 1'b1; rst_n = 1'b0; match0 = 1'b0; match1 = 1'b0;
    model0(1'b0, 1, 10);
    model_on1 = 1'b1; rise1 = 1; hold1 = 10; delay_left1 = 0; busy_left1 = 0;
    tx_busy1 = 1'b0; prev_busy1 = 1'b0;

    // reset values
    do_reset();
    check_zero0("reset");
    check("reset_tx_start1", tx_start1, 0);
    check("reset_reply_busy1", reply_busy1, 0);

    // cycle-by-cycle handshake vectors, busy driven by hand
    for (int i = 0; i < 12; i++) begin
      enable = vecs[i].en; match0 = vecs[i].m; tx_busy0 = vecs[i].busy;
      tick();
      check($sformatf("vec%0d_tx_start", i), tx_start0, vecs[i].exp_start);
      check($sformatf("vec%0d_reply_busy", i), reply_busy0, vecs[i].exp_rbusy);
      check($sformatf("vec%0d_dropped", i), dropped0, vecs[i].exp_drop);
      check($sformatf("vec%0d_tx_data", i), tx_data0, vecs[i].exp_data);
    end
    enable = 1'b1;

    // single reply, CRLF
    do_reset(); model0(1'b1, 1, 10); clear_logs();
    m = cyc; pulse0(); run_until(m + 90);
    check("t1_starts", start_cyc0.size(), 6);
    for (int k = 0; k < 6; k++) if (k < start_cyc0.size()) begin
      check($sformatf("t1_data%0d", k), start_dat0[k], crlf_bytes[k].data);
      check($sformatf("t1_cyc%0d", k), start_cyc0[k], m + 1 + crlf_bytes[k].offset);
    end
    check("t1_dones", done_cyc0.size(), 1);
    if (done_cyc0.size() > 0) check("t1_done_cyc", done_cyc0[0], m + 73);
    check("t1_count", reply_count0, 1);
    check("t1_reply_busy", reply_busy0, 0);

    // queued second reply and a dropped third match
    do_reset(); model0(1'b1, 1, 10); clear_logs();
    m = cyc; pulse0();
    run_until(m + 28); pulse0();
    run_until(m + 40); pulse0();
    run_until(m + 180);
    check("t2_starts", start_cyc0.size(), 12);
    check("t2_drops", drop_cyc0.size(), 1);
    if (drop_cyc0.size() > 0) check("t2_drop_cyc", drop_cyc0[0], m + 41);
    check("t2_dones", done_cyc0.size(), 2);
    if (done_cyc0.size() > 1) begin
      check("t2_done0", done_cyc0[0], m + 73);
      check("t2_done1", done_cyc0[1], m + 146);
    end
    if (start_cyc0.size() > 6) begin
      check("t2_restart_cyc", start_cyc0[6], m + 74);
      check("t2_restart_data", start_dat0[6], 8'h50);
    end
    check("t2_count", reply_count0, 2);

    // acknowledge never arrives
    do_reset(); model0(1'b0, 1, 10); clear_logs();
    m = cyc; pulse0(); run_until(m + 40);
    check("t3_starts", start_cyc0.size(), 1);
    if (start_cyc0.size() > 0) check("t3_start_cyc", start_cyc0[0], m + 1);
    check("t3_errors", err_cyc0.size(), 1);
    if (err_cyc0.size() > 0) check("t3_err_cyc", err_cyc0[0], m + 17);
    check("t3_reply_busy", reply_busy0, 0);
    check("t3_count", reply_count0, 0);

    // acknowledge on the last allowed cycle wins
    model0(1'b1, 15, 10); clear_logs();
    pulse0(); repeat (250) tick();
    check("t3b_errors", err_cyc0.size(), 0);
    check("t3b_dones", done_cyc0.size(), 1);
    check("t3b_count", reply_count0, 1);

    // inter-byte gap, no CRLF
    clear_logs();
    m = cyc; match1 = 1'b1; tick(); match1 = 1'b0; run_until(m + 90);
    check("t4_starts", start_cyc1.size(), 4);
    for (int k = 0; k < 4; k++) if (k < start_cyc1.size()) begin
      check($sformatf("t4_data%0d", k), start_dat1[k], gap_bytes[k].data);
      check($sformatf("t4_cyc%0d", k), start_cyc1[k], m + 1 + gap_bytes[k].offset);
      if (k > 0 && k - 1 < fall_cyc1.size())
        check($sformatf("t4_gap%0d", k), start_cyc1[k] - fall_cyc1[k-1], 4);
    end
    check("t4_dones", done_cyc1.size(), 1);
    if (done_cyc1.size() > 0) check("t4_done_cyc", done_cyc1[0], m + 58);
    check("t4_count", reply_count1, 1);

    // enable low
    do_reset(); model0(1'b1, 1, 10); clear_logs();
    enable = 1'b0; pulse0(); repeat (20) tick();
    check("t5_idle_starts", start_cyc0.size(), 0);
    check("t5_idle_drops", drop_cyc0.size(), 0);
    enable = 1'b1;
    m = cyc; pulse0();
    run_until(m + 5); pulse0();
    run_until(m + 10); enable = 1'b0;
    run_until(m + 20); pulse0();
    run_until(m + 150);
    check("t5_starts", start_cyc0.size(), 6);
    check("t5_drops", drop_cyc0.size(), 0);
    check("t5_dones", done_cyc0.size(), 1);
    check("t5_count", reply_count0, 1);

    // reset in the middle of a reply
    enable = 1'b1; clear_logs();
    m = cyc; pulse0();
    run_until(m + 5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_zero0("t6");
    run_until(m + 15); clear_logs();
    pulse0(); repeat (20) tick();
    check("t6_starts", start_cyc0.size() > 0, 1);
    if (start_cyc0.size() > 0) begin
      check("t6_start_cyc", start_cyc0[0], m + 16);
      check("t6_start_data", start_dat0[0], 8'h50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
